ant_motion_ctrl: RTL
====================

// Module: ant_motion_ctrl
// PURPOSE
//  Downstream stage of the RoboAnt 5-state FSM. Consumes its TL/TR/F commands, paces them into
//  timed left/right motor drive, and tracks ant heading, (x,y) grid position and step count.
//  Exposes cmd_ready so the FSM can later be stalled while a move is in progress.
// PARAMETERS
//  COORD_W     8   width of signed two's-complement pos_x/pos_y
//  FWD_CYCLES  4   motor cycles per forward step (>=1)
//  TURN_CYCLES 2   motor cycles per 90-degree turn (>=1)
//  STEP_W      16  width of step_count
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous reset, active-high
//  TL           in   1        turn-left command from FSM
//  TR           in   1        turn-right command from FSM
//  F            in   1        forward command from FSM
//  cmd_ready    out  1        1 = IDLE, commands sampled this edge
//  motor_l_en   out  1        left motor enable
//  motor_l_dir  out  1        left motor direction (1 = forward)
//  motor_r_en   out  1        right motor enable
//  motor_r_dir  out  1        right motor direction (1 = forward)
//  heading      out  2        0=N 1=E 2=S 3=W
//  pos_x        out  COORD_W  signed x position
//  pos_y        out  COORD_W  signed y position
//  step_count   out  STEP_W   completed forward steps, saturating
//  cmd_err      out  1        one-cycle pulse on illegal command
//  at_origin    out  1        pos_x==0 && pos_y==0 (combinational from regs)
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; all motor_* 0; heading 0; pos 0,0; step_count 0;
//   cmd_err 0; at_origin 1. rst beats every other event, including mid-move: the move is
//   aborted and heading, position and count return to reset values.
//  States: IDLE, TURN_L, TURN_R, FWD. All outputs are registered except at_origin.
//  IDLE: commands are sampled only on an edge where cmd_ready=1. Commands while busy are ignored.
//   TL&TR (any F)     -> stay IDLE, cmd_err=1 for 1 cycle, no other change
//   TL only           -> TURN_L;  TR only -> TURN_R;  F only -> FWD
//   TL&F / TR&F       -> TURN_x, then FWD directly, with no IDLE cycle between
//   none              -> stay IDLE
//  Counter loads N-1 on state entry (N = TURN_CYCLES or FWD_CYCLES). It decrements each cycle.
//   The state exits on the edge where counter==0, so the motors are driven for exactly N cycles.
//  Motor drive while in state:
//   FWD:    l_en=1 l_dir=1  r_en=1 r_dir=1
//   TURN_L: l_en=1 l_dir=0  r_en=1 r_dir=1
//   TURN_R: l_en=1 l_dir=1  r_en=1 r_dir=0
//   IDLE:   all 0
//  Heading updates on the exit edge of a turn: TR -> +1 mod 4, TL -> -1 mod 4.
//  Position updates on the exit edge of FWD: N y+1, E x+1, S y-1, W x-1.
//   Position wraps two's complement (+max -> -max-1).
//   On the same edge step_count increments, saturating at all-ones.
//  After any move, cmd_ready=1 on the first IDLE cycle. Minimum gap between moves is 1 cycle.
//  Latency: command sampled at edge k -> motors on in cycle k+1 -> cmd_ready back in cycle k+N+1.
//   For a compound move, cmd_ready returns in cycle k+TURN_CYCLES+FWD_CYCLES+1.
// TESTING
//  1 Hold rst 2 cycles -> all outputs at reset values, cmd_ready=1, at_origin=1.
//  2 F=1 for 1 cycle, heading N -> 4 cycles of both motors fwd, then pos_y=1, step_count=1.
//  3 TR&F from N -> 2 cycles with r_dir=0, then 4 fwd cycles -> heading=1, pos_x=1;
//    cmd_ready low 6 cycles.
//  4 TL from N -> heading=3. Then TL&TR -> cmd_err pulses exactly 1 cycle, no motor activity.
//  5 pos_x=127, heading E, F -> pos_x=-128 (wrap). Commands during busy are ignored.
//  6 rst asserted in cycle 2 of FWD -> next cycle IDLE, motors 0, position unchanged from reset.

Source files
------------

// File: rtl/ant_motion_ctrl.sv
// Motion stage behind the RoboAnt FSM: paces TL/TR/F into timed motor drive and
// keeps heading, grid position and completed-step count.
module ant_motion_ctrl #(
    parameter int COORD_W     = 8,
    parameter int FWD_CYCLES  = 4,
    parameter int TURN_CYCLES = 2,
    parameter int STEP_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      TL,
    input  logic                      TR,
    input  logic                      F,
    output logic                      cmd_ready,
    output logic                      motor_l_en,
    output logic                      motor_l_dir,
    output logic                      motor_r_en,
    output logic                      motor_r_dir,
    output logic [1:0]                heading,
    output logic signed [COORD_W-1:0] pos_x,
    output logic signed [COORD_W-1:0] pos_y,
    output logic [STEP_W-1:0]         step_count,
    output logic                      cmd_err,
    output logic                      at_origin
);

    typedef enum logic [1:0] {IDLE, TURN_L, TURN_R, FWD} state_t;

    localparam int MAX_CYC = (FWD_CYCLES > TURN_CYCLES) ? FWD_CYCLES : TURN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]          FWD_LOAD  = CNT_W'(FWD_CYCLES - 1);
    localparam logic [CNT_W-1:0]          TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic signed [COORD_W-1:0] COORD_ONE = COORD_W'(1);
    localparam logic [STEP_W-1:0]         STEP_ONE  = STEP_W'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             fwd_pending_reg;
    logic             cnt_done;

    // Motor pattern {l_en, l_dir, r_en, r_dir} for the state being entered.
    function automatic logic [3:0] drive(input state_t s);
        case (s)
            FWD:     drive = 4'b1111;
            TURN_L:  drive = 4'b1011;
            TURN_R:  drive = 4'b1110;
            default: drive = 4'b0000;
        endcase
    endfunction

    assign cnt_done  = (cnt_reg == '0);
    assign at_origin = (pos_x == '0) && (pos_y == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!(TL && TR)) begin
                    if (TL)      state_next = TURN_L;
                    else if (TR) state_next = TURN_R;
                    else if (F)  state_next = FWD;
                end
            end
            TURN_L, TURN_R: begin
                // A compound command chains straight into FWD with no idle cycle.
                if (cnt_done) state_next = fwd_pending_reg ? FWD : IDLE;
            end
            FWD: begin
                if (cnt_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            fwd_pending_reg <= 1'b0;
            cmd_ready       <= 1'b1;
            motor_l_en      <= 1'b0;
            motor_l_dir     <= 1'b0;
            motor_r_en      <= 1'b0;
            motor_r_dir     <= 1'b0;
            heading         <= 2'd0;
            pos_x           <= '0;
            pos_y           <= '0;
            step_count      <= '0;
            cmd_err         <= 1'b0;
        end else begin
            state_reg <= state_next;
            cmd_ready <= (state_next == IDLE);
            {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir} <= drive(state_next);
            cmd_err   <= (state_reg == IDLE) && TL && TR;

            if (state_next != state_reg)
                cnt_reg <= (state_next == FWD) ? FWD_LOAD : TURN_LOAD;
            else if (!cnt_done)
                cnt_reg <= cnt_reg - CNT_ONE;

            if (state_reg == IDLE)
                fwd_pending_reg <= F;

            if (state_reg == TURN_R && cnt_done) heading <= heading + 2'd1;
            if (state_reg == TURN_L && cnt_done) heading <= heading - 2'd1;

            if (state_reg == FWD && cnt_done) begin
                case (heading)
                    2'd0:    pos_y <= pos_y + COORD_ONE;
                    2'd1:    pos_x <= pos_x + COORD_ONE;
                    2'd2:    pos_y <= pos_y - COORD_ONE;
                    default: pos_x <= pos_x - COORD_ONE;
                endcase
                if (step_count != '1) step_count <= step_count + STEP_ONE;
            end
        end
    end

endmodule
